// File: rtl/program_loader.sv
// program_loader: fills the core's instruction cache and data memory from a
// host valid/ready word stream, then raises load_done.
//   clk, rst        : clock, synchronous active-high reset
//   start           : begins a load from IDLE or DONE
//   in_valid/in_data/in_ready : host word handshake
//   cache_we/cache_addr/cache_wdata : instruction cache write port
//   mem_we/mem_addr/mem_wdata       : data memory write port
//   load_done       : load complete, held until next start or rst
//   err_overflow    : sticky, an instruction or bubble slot was dropped
module program_loader #(
  parameter int NUM_INSTRUCTIONS = 16,
  parameter int CACHE_DEPTH      = 48,
  parameter int WORDS_IN_MEMORY  = 32,
  parameter int NUM_SIZE         = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               in_valid,
  input  logic [31:0]                        in_data,
  output logic                               in_ready,
  output logic                               cache_we,
  output logic [$clog2(CACHE_DEPTH)-1:0]     cache_addr,
  output logic [31:0]                        cache_wdata,
  output logic                               mem_we,
  output logic [$clog2(WORDS_IN_MEMORY)-1:0] mem_addr,
  output logic [NUM_SIZE-1:0]                mem_wdata,
  output logic                               load_done,
  output logic                               err_overflow
);

  localparam int CAW = $clog2(CACHE_DEPTH);
  localparam int MAW = $clog2(WORDS_IN_MEMORY);
  localparam int ICW = $clog2(NUM_INSTRUCTIONS + 1);
  localparam int NI_M1 = NUM_INSTRUCTIONS - 1;
  localparam int WL    = WORDS_IN_MEMORY - 1;

  localparam logic [CAW:0]   DEPTH_P = CACHE_DEPTH[CAW:0];
  localparam logic [CAW:0]   PTR_ONE = 1;
  localparam logic [ICW-1:0] NI_P    = NUM_INSTRUCTIONS[ICW-1:0];
  localparam logic [ICW-1:0] NI_M1_P = NI_M1[ICW-1:0];
  localparam logic [ICW-1:0] IC_ONE  = 1;
  localparam logic [MAW-1:0] WL_P    = WL[MAW-1:0];
  localparam logic [MAW-1:0] DC_ONE  = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_INSTR, S_BUBBLE, S_FILL, S_DATA, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CAW:0]         ptr_q, ptr_d;
  logic [ICW-1:0]       icnt_q, icnt_d;
  logic [MAW-1:0]       dcnt_q, dcnt_d;
  logic [1:0]           bub_q, bub_d;
  logic                 in_ready_q, in_ready_d;
  logic                 cache_we_q, cache_we_d;
  logic [CAW-1:0]       cache_addr_q, cache_addr_d;
  logic [31:0]          cache_wdata_q, cache_wdata_d;
  logic                 mem_we_q, mem_we_d;
  logic [MAW-1:0]       mem_addr_q, mem_addr_d;
  logic [NUM_SIZE-1:0]  mem_wdata_q, mem_wdata_d;
  logic                 load_done_q, load_done_d;
  logic                 err_q, err_d;
  logic                 hs;
  logic                 bub_end;
  logic [5:0]           opcode;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    icnt_d        = icnt_q;
    dcnt_d        = dcnt_q;
    bub_d         = bub_q;
    cache_we_d    = 1'b0;
    cache_addr_d  = cache_addr_q;
    cache_wdata_d = '0;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    err_d         = err_q;
    bub_end       = 1'b0;
    hs            = in_valid && in_ready_q;
    opcode        = in_data[23:18];

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_INSTR;
          ptr_d   = '0;
          icnt_d  = '0;
          dcnt_d  = '0;
          bub_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_INSTR: begin
        if (hs) begin
          icnt_d = icnt_q + IC_ONE;
          if (ptr_q < DEPTH_P) begin
            cache_we_d    = 1'b1;
            cache_addr_d  = ptr_q[CAW-1:0];
            cache_wdata_d = in_data;
            ptr_d         = ptr_q + PTR_ONE;
          end else begin
            err_d = 1'b1;
          end
          if (opcode >= 6'd2 && opcode <= 6'd5) begin
            bub_d   = 2'd2;
            state_d = S_BUBBLE;
          end else if (icnt_q == NI_M1_P) begin
            // A full cache skips FILL so the load latency is unchanged.
            state_d = (ptr_d < DEPTH_P) ? S_FILL : S_DATA;
          end
        end
      end
      S_BUBBLE: begin
        if (ptr_q < DEPTH_P) begin
          cache_we_d   = 1'b1;
          cache_addr_d = ptr_q[CAW-1:0];
          ptr_d        = ptr_q + PTR_ONE;
          bub_d        = bub_q - 2'd1;
          bub_end      = (bub_q == 2'd1);
        end else begin
          err_d   = 1'b1;
          bub_d   = '0;
          bub_end = 1'b1;
        end
        if (bub_end) begin
          if (icnt_q == NI_P) state_d = (ptr_d < DEPTH_P) ? S_FILL : S_DATA;
          else                state_d = S_INSTR;
        end
      end
      S_FILL: begin
        if (ptr_q < DEPTH_P) begin
          cache_we_d   = 1'b1;
          cache_addr_d = ptr_q[CAW-1:0];
          ptr_d        = ptr_q + PTR_ONE;
          if (ptr_d >= DEPTH_P) state_d = S_DATA;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (hs) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = dcnt_q;
          mem_wdata_d = in_data[NUM_SIZE-1:0];
          dcnt_d      = dcnt_q + DC_ONE;
          if (dcnt_q == WL_P) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_INSTR) || (state_d == S_DATA);
    // Registered one cycle behind DONE entry so it follows the last mem_we.
    load_done_d = (state_q == S_DONE) && (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      icnt_q        <= '0;
      dcnt_q        <= '0;
      bub_q         <= '0;
      in_ready_q    <= 1'b0;
      cache_we_q    <= 1'b0;
      cache_addr_q  <= '0;
      cache_wdata_q <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      load_done_q   <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      icnt_q        <= icnt_d;
      dcnt_q        <= dcnt_d;
      bub_q         <= bub_d;
      in_ready_q    <= in_ready_d;
      cache_we_q    <= cache_we_d;
      cache_addr_q  <= cache_addr_d;
      cache_wdata_q <= cache_wdata_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      load_done_q   <= load_done_d;
      err_q         <= err_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign cache_we     = cache_we_q;
  assign cache_addr   = cache_addr_q;
  assign cache_wdata  = cache_wdata_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign load_done    = load_done_q;
  assign err_overflow = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: instance a uses default parameters,
// instance b uses a 20-entry cache to exercise overflow.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        valid_a = 1'b0, valid_b = 1'b0;
  logic [31:0] data_a = '0, data_b = '0;

  logic        in_ready_a, cache_we_a, mem_we_a, load_done_a, err_a;
  logic [5:0]  cache_addr_a;
  logic [31:0] cache_wdata_a;
  logic [4:0]  mem_addr_a;
  logic [15:0] mem_wdata_a;

  logic        in_ready_b, cache_we_b, mem_we_b, load_done_b, err_b;
  logic [4:0]  cache_addr_b;
  logic [31:0] cache_wdata_b;
  logic [4:0]  mem_addr_b;
  logic [15:0] mem_wdata_b;

  always #5 clk = ~clk;

  program_loader u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(valid_a), .in_data(data_a),
    .in_ready(in_ready_a), .cache_we(cache_we_a), .cache_addr(cache_addr_a),
    .cache_wdata(cache_wdata_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .load_done(load_done_a), .err_overflow(err_a)
  );

  program_loader #(.CACHE_DEPTH(20)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(valid_b), .in_data(data_b),
    .in_ready(in_ready_b), .cache_we(cache_we_b), .cache_addr(cache_addr_b),
    .cache_wdata(cache_wdata_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .load_done(load_done_b), .err_overflow(err_b)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t_start = 0;
  logic [31:0] stim [48];
  logic [31:0] exp_cache [48];

  // Monitor state, written only by the monitor process.
  logic [31:0] cache_m [2][48];
  int          cwr [2][48];
  logic [15:0] mem_m [2][32];
  int          mwr [2][32];
  int          hs [2], stall [2], bad [2], nohs [2], done_cyc [2];
  bit          done_seen [2];
  logic        m_st, m_cw, m_mw, m_v, m_r, m_ld;
  int          m_ca, m_ma, m_dep;
  logic [31:0] m_cd;
  logic [15:0] m_md;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        m_st = start_a; m_cw = cache_we_a; m_mw = mem_we_a; m_v = valid_a;
        m_r = in_ready_a; m_ld = load_done_a; m_ca = int'(cache_addr_a);
        m_ma = int'(mem_addr_a); m_cd = cache_wdata_a; m_md = mem_wdata_a; m_dep = 48;
      end else begin
        m_st = start_b; m_cw = cache_we_b; m_mw = mem_we_b; m_v = valid_b;
        m_r = in_ready_b; m_ld = load_done_b; m_ca = int'(cache_addr_b);
        m_ma = int'(mem_addr_b); m_cd = cache_wdata_b; m_md = mem_wdata_b; m_dep = 20;
      end
      if (m_st) begin
        for (int i = 0; i < 48; i++) begin cache_m[d][i] = '0; cwr[d][i] = 0; end
        for (int i = 0; i < 32; i++) begin mem_m[d][i] = '0; mwr[d][i] = 0; end
        hs[d] = 0; stall[d] = 0; bad[d] = 0; nohs[d] = 0; done_cyc[d] = 0;
        done_seen[d] = 1'b0;
      end else begin
        if (m_cw) begin
          if (m_ca >= m_dep) bad[d]++;
          else begin cache_m[d][m_ca] = m_cd; cwr[d][m_ca]++; end
        end
        if (m_mw) begin
          if (m_ma >= hs[d] - 16) nohs[d]++;
          mem_m[d][m_ma] = m_md;
          mwr[d][m_ma]++;
        end
        if (m_v && m_r) hs[d]++;
        if (!m_r && hs[d] > 0 && hs[d] < 16) stall[d]++;
        if (m_ld && !done_seen[d]) begin done_seen[d] = 1'b1; done_cyc[d] = cyc; end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Instruction word i with opcode op; data words carry a distinct low half.
  task automatic set_program(input logic [5:0] ops [16]);
    for (int i = 0; i < 16; i++) stim[i] = {8'(i + 16), ops[i], 18'(i * 7 + 3)};
    for (int i = 0; i < 32; i++) stim[16 + i] = {16'hDEAD ^ 16'(i), 16'(i * 257 + 7)};
  endtask

  // Expected cache image: instructions packed with two zero slots after
  // opcodes 2..5, truncated at depth, zeros elsewhere.
  task automatic build_expected(input int depth);
    int p = 0;
    logic [5:0] op;
    for (int a = 0; a < 48; a++) exp_cache[a] = '0;
    for (int i = 0; i < 16; i++) begin
      op = stim[i][23:18];
      if (p < depth) begin exp_cache[p] = stim[i]; p++; end
      if (op >= 6'd2 && op <= 6'd5)
        for (int b = 0; b < 2; b++) if (p < depth) begin exp_cache[p] = '0; p++; end
    end
  endtask

  task automatic feed(input int d, input bit gaps, input int stop_at);
    int k = 0;
    int guard = 0;
    logic v, r;
    if (d == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    t_start = cyc;
    while (k < stop_at && guard < 1000) begin
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (d == 0) begin valid_a = v; data_a = stim[k]; r = in_ready_a; end
      else        begin valid_b = v; data_b = stim[k]; r = in_ready_b; end
      @(posedge clk); #1;
      if (v && r) k++;
      guard++;
    end
    valid_a = 1'b0; valid_b = 1'b0;
  endtask

  task automatic wait_done(input int d);
    int g = 0;
    while (!(d == 0 ? load_done_a : load_done_b) && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    @(posedge clk); #1;
  endtask

  task automatic compare_all(input int d, input int depth, input string tag);
    int cerr = 0;
    int merr = 0;
    for (int a = 0; a < depth; a++)
      if (cache_m[d][a] !== exp_cache[a] || cwr[d][a] != 1) cerr++;
    for (int i = 0; i < 32; i++)
      if (mem_m[d][i] !== stim[16 + i][15:0] || mwr[d][i] != 1) merr++;
    chk({tag, "_cache_mismatch"}, cerr, 0);
    chk({tag, "_mem_mismatch"}, merr, 0);
    chk({tag, "_write_without_hs"}, nohs[d], 0);
    chk({tag, "_load_done"}, {31'd0, d == 0 ? load_done_a : load_done_b}, 1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops [16];

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready_a, 0);
    chk("rst_cache_we", cache_we_a, 0);
    chk("rst_mem_we", mem_we_a, 0);
    chk("rst_load_done", load_done_a, 0);
    chk("rst_err", err_a, 0);

    // All opcode 0, continuous valid
    for (int i = 0; i < 16; i++) ops[i] = 6'd0;
    set_program(ops); build_expected(48);
    feed(0, 1'b0, 48); wait_done(0);
    compare_all(0, 48, "plain");
    chk("plain_latency", done_cyc[0] - t_start, 81);
    chk("plain_err", err_a, 0);
    chk("plain_stall", stall[0], 0);
    chk("plain_cache16", cache_m[0][16], 0);

    // Opcode 1 then opcode 3: one bubble pair after instruction 1
    ops[0] = 6'd1; ops[1] = 6'd3;
    set_program(ops); build_expected(48);
    feed(0, 1'b0, 48); wait_done(0);
    compare_all(0, 48, "bub");
    chk("bub_c1", cache_m[0][1], stim[1]);
    chk("bub_c2", cache_m[0][2], 0);
    chk("bub_c3", cache_m[0][3], 0);
    chk("bub_c4", cache_m[0][4], stim[2]);
    chk("bub_stall", stall[0], 2);
    chk("bub_latency", done_cyc[0] - t_start, 81);

    // All opcode 5: cache exactly filled by instructions and bubbles
    for (int i = 0; i < 16; i++) ops[i] = 6'd5;
    set_program(ops); build_expected(48);
    feed(0, 1'b0, 48); wait_done(0);
    compare_all(0, 48, "full");
    chk("full_err", err_a, 0);
    chk("full_stall", stall[0], 30);
    chk("full_c47", cache_m[0][47], 0);
    chk("full_c45", cache_m[0][45], stim[15]);

    // Overflow on a 20-entry cache with 16 opcode-2 instructions
    for (int i = 0; i < 16; i++) ops[i] = 6'd2;
    set_program(ops); build_expected(20);
    feed(1, 1'b0, 48); wait_done(1);
    compare_all(1, 20, "ovf");
    chk("ovf_err", err_b, 1);
    chk("ovf_bad_addr", bad[1], 0);
    chk("ovf_handshakes", hs[1], 48);

    // Random valid gaps, mixed program
    for (int i = 0; i < 16; i++) ops[i] = 6'(i % 7);
    set_program(ops); build_expected(48);
    feed(0, 1'b1, 48); wait_done(0);
    compare_all(0, 48, "gaps");
    chk("gaps_err", err_a, 0);
    chk("gaps_handshakes", hs[0], 48);

    // Reset during DATA at word 10, then reload
    feed(0, 1'b0, 26);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_flags", {27'd0, in_ready_a, cache_we_a, mem_we_a, load_done_a, err_a}, 0);
    chk("midrst_mem_addr", mem_addr_a, 0);
    chk("midrst_mem_wdata", mem_wdata_a, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    feed(0, 1'b0, 48); wait_done(0);
    compare_all(0, 48, "reload");
    chk("reload_latency", done_cyc[0] - t_start, 81);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
